// File: rtl/alu_pkg.sv
// Shared ALU encodings and arbiter state type for the ALU sharing logic.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_BR   = 4'b0010;
  localparam logic [3:0] ALU_JAL  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_JALR = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant records the most recent winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       any,
  output logic       last_grant
);

  // gnt_idx falls back to last_grant so the operand mux stays stable when idle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_idx = last_grant;
    any     = 1'b0;
    if (en) begin
      unique case (req)
        2'b01:   begin gnt_idx = 1'b0;        any = 1'b1; end
        2'b10:   begin gnt_idx = 1'b1;        any = 1'b1; end
        2'b11:   begin gnt_idx = ~last_grant; any = 1'b1; end
        default: ;
      endcase
    end
    gnt = any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  // A grant is only given to a valid requester, so any grant is an acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n)   last_grant <= 1'b1;
    else if (any) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with a
// registered, per-port response and saturating per-port grant counters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [XLEN-1:0]  req_in1_0,
  input  logic [XLEN-1:0]  req_in1_1,
  input  logic [XLEN-1:0]  req_in2_0,
  input  logic [XLEN-1:0]  req_in2_1,
  input  logic [3:0]       req_sel_0,
  input  logic [3:0]       req_sel_1,
  input  logic [2:0]       req_f3_0,
  input  logic [2:0]       req_f3_1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_zero,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [3:0]       alu_sel,
  output logic [2:0]       alu_func3,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] grant_cnt_0,
  output logic [CNT_W-1:0] grant_cnt_1
);

  state_t     state, state_nxt;
  logic       owner;
  logic       can_accept;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       accept;
  logic       last_grant;

  // Accept while idle, or while the held response is consumed this cycle.
  assign can_accept = rst_n & ((state == ST_IDLE) | rsp_ready[owner]);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (can_accept),
    .req        (req_valid),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .any        (accept),
    .last_grant (last_grant)
  );

  assign req_ready = gnt;

  assign alu_in1   = gnt_idx ? req_in1_1 : req_in1_0;
  assign alu_in2   = gnt_idx ? req_in2_1 : req_in2_0;
  assign alu_sel   = gnt_idx ? req_sel_1 : req_sel_0;
  assign alu_func3 = gnt_idx ? req_f3_1  : req_f3_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)                                    state_nxt = ST_HOLD;
    else if (state == ST_HOLD && rsp_ready[owner]) state_nxt = ST_IDLE;
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == ST_HOLD) rsp_valid = owner ? 2'b10 : 2'b01;
  end

  // The result registers are reset too: they drive a visible shared bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      owner      <= 1'b0;
    end else if (accept) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      owner      <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_0 <= '0;
      grant_cnt_1 <= '0;
    end else begin
      if (gnt[0] && grant_cnt_0 != '1) grant_cnt_0 <= grant_cnt_0 + 1'b1;
      if (gnt[1] && grant_cnt_1 != '1) grant_cnt_1 <= grant_cnt_1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the
// shared ALU port, plus a narrow-counter instance for saturation.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_in1_0, req_in1_1, req_in2_0, req_in2_1;
  logic [3:0]  req_sel_0, req_sel_1;
  logic [2:0]  req_f3_0, req_f3_1;
  logic [31:0] rsp_result, alu_in1, alu_in2, alu_result;
  logic        rsp_zero, alu_zero;
  logic [3:0]  alu_sel;
  logic [2:0]  alu_func3;
  logic [15:0] grant_cnt_0, grant_cnt_1;

  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [31:0] s_rsp_result, s_alu_in1, s_alu_in2;
  logic        s_rsp_zero;
  logic [3:0]  s_alu_sel;
  logic [2:0]  s_alu_func3;
  logic [1:0]  s_cnt_0, s_cnt_1;
  logic [31:0] s_alu_result = 32'h0;
  logic        s_alu_zero = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1_0(req_in1_0), .req_in1_1(req_in1_1), .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
    .req_sel_0(req_sel_0), .req_sel_1(req_sel_1), .req_f3_0(req_f3_0), .req_f3_1(req_f3_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_func3(alu_func3),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
  );

  alu_share_arbiter #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_in1_0(req_in1_0), .req_in1_1(req_in1_1), .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
    .req_sel_0(req_sel_0), .req_sel_1(req_sel_1), .req_f3_0(req_f3_0), .req_f3_1(req_f3_1),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero),
    .alu_in1(s_alu_in1), .alu_in2(s_alu_in2), .alu_sel(s_alu_sel), .alu_func3(s_alu_func3),
    .alu_result(s_alu_result), .alu_zero(s_alu_zero),
    .grant_cnt_0(s_cnt_0), .grant_cnt_1(s_cnt_1)
  );

  // Behavioural ALU: branches return result 0 with the taken flag on zero;
  // undefined select codes return 0/0.
  always_comb begin
    alu_result = 32'h0;
    alu_zero   = 1'b0;
    case (alu_sel)
      ALU_ADD:  alu_result = alu_in1 + alu_in2;
      ALU_SUB:  alu_result = alu_in1 - alu_in2;
      ALU_JAL,
      ALU_JALR: alu_result = alu_in1 + 32'd4;
      ALU_OR:   alu_result = alu_in1 | alu_in2;
      ALU_AND:  alu_result = alu_in1 & alu_in2;
      ALU_LUI:  alu_result = alu_in2;
      ALU_XOR:  alu_result = alu_in1 ^ alu_in2;
      ALU_SRL:  alu_result = alu_in1 >> alu_in2[4:0];
      ALU_SLL:  alu_result = alu_in1 << alu_in2[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      ALU_SLT:  alu_result = {31'h0, $signed(alu_in1) < $signed(alu_in2)};
      ALU_SLTU: alu_result = {31'h0, alu_in1 < alu_in2};
      default:  alu_result = 32'h0;
    endcase
    case (alu_sel)
      ALU_BR: begin
        case (alu_func3)
          F3_BEQ:  alu_zero = (alu_in1 == alu_in2);
          F3_BNE:  alu_zero = (alu_in1 != alu_in2);
          F3_BLT:  alu_zero = ($signed(alu_in1) <  $signed(alu_in2));
          F3_BGE:  alu_zero = ($signed(alu_in1) >= $signed(alu_in2));
          F3_BLTU: alu_zero = (alu_in1 <  alu_in2);
          F3_BGEU: alu_zero = (alu_in1 >= alu_in2);
          default: alu_zero = 1'b0;
        endcase
      end
      4'b1100, 4'b1110: alu_zero = 1'b0;
      default:          alu_zero = (alu_result == 32'h0);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b00;
    req_in1_0 = 32'h0; req_in2_0 = 32'h0; req_sel_0 = ALU_ADD; req_f3_0 = F3_BEQ;
    req_in1_1 = 32'h0; req_in2_1 = 32'h0; req_sel_1 = ALU_ADD; req_f3_1 = F3_BEQ;

    // Reset state
    #2;
    check("rst_req_ready", {30'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_zero", {31'h0, rsp_zero}, 32'h0);
    check("rst_cnt0", {16'h0, grant_cnt_0}, 32'h0);
    check("rst_cnt1", {16'h0, grant_cnt_1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;

    // Port 0 alone: ADD 5+7
    req_valid = 2'b01; rsp_ready = 2'b11;
    req_in1_0 = 32'd5; req_in2_0 = 32'd7; req_sel_0 = ALU_ADD;
    #1;
    check("p0_req_ready", {30'h0, req_ready}, 32'h1);
    check("p0_alu_in1", alu_in1, 32'd5);
    check("p0_alu_sel", {28'h0, alu_sel}, {28'h0, ALU_ADD});
    tick();
    check("p0_rsp_valid", {30'h0, rsp_valid}, 32'h1);
    check("p0_rsp_result", rsp_result, 32'd12);
    check("p0_rsp_zero", {31'h0, rsp_zero}, 32'h0);
    check("p0_cnt0", {16'h0, grant_cnt_0}, 32'd1);
    req_valid = 2'b00;
    tick();
    check("p0_idle_valid", {30'h0, rsp_valid}, 32'h0);
    check("p0_idle_result_kept", rsp_result, 32'd12);

    // Both valid: last grant was port 0, so port 1 leads and grants alternate
    req_valid = 2'b11;
    req_in1_0 = 32'd10;   req_in2_0 = 32'd3;    req_sel_0 = ALU_SUB;
    req_in1_1 = 32'hF0;   req_in2_1 = 32'h0F;   req_sel_1 = ALU_XOR;
    #1;
    check("alt_ready_a", {30'h0, req_ready}, 32'h2);
    tick();
    check("alt1_valid", {30'h0, rsp_valid}, 32'h2);
    check("alt1_result", rsp_result, 32'hFF);
    check("alt1_ready", {30'h0, req_ready}, 32'h1);
    tick();
    check("alt2_valid", {30'h0, rsp_valid}, 32'h1);
    check("alt2_result", rsp_result, 32'd7);
    check("alt2_ready", {30'h0, req_ready}, 32'h2);
    tick();
    check("alt3_valid", {30'h0, rsp_valid}, 32'h2);
    check("alt3_result", rsp_result, 32'hFF);
    tick();
    check("alt4_valid", {30'h0, rsp_valid}, 32'h1);
    check("alt4_result", rsp_result, 32'd7);
    req_valid = 2'b00;
    tick();
    check("alt_idle_valid", {30'h0, rsp_valid}, 32'h0);
    check("alt_cnt0", {16'h0, grant_cnt_0}, 32'd3);
    check("alt_cnt1", {16'h0, grant_cnt_1}, 32'd2);

    // Undefined select code is forwarded; ALU yields 0/0
    req_valid = 2'b01; req_in1_0 = 32'd3; req_in2_0 = 32'd4; req_sel_0 = 4'b1100;
    #1;
    check("ill_alu_sel", {28'h0, alu_sel}, 32'hC);
    tick();
    check("ill_valid", {30'h0, rsp_valid}, 32'h1);
    check("ill_result", rsp_result, 32'h0);
    check("ill_zero", {31'h0, rsp_zero}, 32'h0);
    req_valid = 2'b00;
    tick();

    // Port 1 branches, back to back through pass-through acceptance
    req_valid = 2'b10; req_sel_1 = ALU_BR; req_f3_1 = F3_BEQ;
    req_in1_1 = 32'h1234; req_in2_1 = 32'h1234;
    #1;
    check("beq_ready", {30'h0, req_ready}, 32'h2);
    check("beq_alu_f3", {29'h0, alu_func3}, {29'h0, F3_BEQ});
    tick();
    check("beq_valid", {30'h0, rsp_valid}, 32'h2);
    check("beq_zero", {31'h0, rsp_zero}, 32'h1);
    check("beq_result", rsp_result, 32'h0);
    req_f3_1 = F3_BLT; req_in1_1 = 32'h1; req_in2_1 = 32'hFFFF_FFFF;
    #1;
    check("blt_pass_ready", {30'h0, req_ready}, 32'h2);
    tick();
    check("blt_zero", {31'h0, rsp_zero}, 32'h0);
    req_f3_1 = F3_BLTU;
    tick();
    check("bltu_valid", {30'h0, rsp_valid}, 32'h2);
    check("bltu_zero", {31'h0, rsp_zero}, 32'h1);
    check("bltu_result", rsp_result, 32'h0);
    req_valid = 2'b00;
    tick();

    // Backpressure on port 0 holds its result and blocks port 1
    req_valid = 2'b01; rsp_ready = 2'b00;
    req_in1_0 = 32'd1; req_in2_0 = 32'd1; req_sel_0 = ALU_ADD;
    #1;
    check("bp_ready0", {30'h0, req_ready}, 32'h1);
    tick();
    check("bp_valid", {30'h0, rsp_valid}, 32'h1);
    check("bp_result", rsp_result, 32'd2);
    req_valid = 2'b10; rsp_ready = 2'b10;
    req_in1_1 = 32'd100; req_in2_1 = 32'd23; req_sel_1 = ALU_ADD;
    #1;
    check("bp_blocked", {30'h0, req_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_ready", {30'h0, req_ready}, 32'h0);
      check("bp_hold_valid", {30'h0, rsp_valid}, 32'h1);
      check("bp_hold_result", rsp_result, 32'd2);
    end
    rsp_ready = 2'b01;
    #1;
    check("bp_release_ready", {30'h0, req_ready}, 32'h2);
    tick();
    check("bp_p1_valid", {30'h0, rsp_valid}, 32'h2);
    check("bp_p1_result", rsp_result, 32'd123);
    check("bp_cnt0", {16'h0, grant_cnt_0}, 32'd5);
    check("bp_cnt1", {16'h0, grant_cnt_1}, 32'd6);
    req_valid = 2'b00; rsp_ready = 2'b11;
    tick();

    // Reset asserted while holding a response
    req_valid = 2'b01; rsp_ready = 2'b00;
    req_in1_0 = 32'd5; req_in2_0 = 32'd7; req_sel_0 = ALU_ADD;
    req_in1_1 = 32'hF0; req_in2_1 = 32'h0F; req_sel_1 = ALU_XOR;
    tick();
    check("mr_hold_valid", {30'h0, rsp_valid}, 32'h1);
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", {30'h0, rsp_valid}, 32'h0);
    check("mr_result", rsp_result, 32'h0);
    check("mr_ready", {30'h0, req_ready}, 32'h0);
    check("mr_cnt0", {16'h0, grant_cnt_0}, 32'h0);
    check("mr_cnt1", {16'h0, grant_cnt_1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 2'b11;
    #1;
    check("mr_first_grant", {30'h0, req_ready}, 32'h1);
    tick();
    check("mr_p0_valid", {30'h0, rsp_valid}, 32'h1);
    check("mr_p0_result", rsp_result, 32'd12);
    check("mr_next_grant", {30'h0, req_ready}, 32'h2);
    tick();
    check("mr_p1_result", rsp_result, 32'hFF);
    req_valid = 2'b00;
    tick();

    // Counter saturation on the 2-bit instance
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    req_valid = 2'b00;
    check("sat_cnt0", {30'h0, s_cnt_0}, 32'd3);
    check("sat_cnt1", {30'h0, s_cnt_1}, 32'd0);
    check("wide_cnt0", {16'h0, grant_cnt_0}, 32'd5);
    tick();
    check("sat_idle_valid", {30'h0, rsp_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
